// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store initiator for a word-only data memory, with read-modify-write sub-word stores
module dmem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        sgn;
    logic        write;
    logic [31:0] wdata;

    // Load result: sub-word lanes are extended, words are rotated right by the byte offset.
    function automatic logic [31:0] load_fmt(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic s);
        logic [4:0]  sh;
        logic [31:0] rot;
        logic [15:0] h;
        sh  = {a, 3'b000};
        rot = (w >> sh) | (w << (6'd32 - {1'b0, sh}));
        h   = a[1] ? w[31:16] : w[15:0];
        return sz[1] ? rot : sz[0] ? {{16{s & h[15]}}, h} : {{24{s & rot[7]}}, rot[7:0]};
    endfunction

    // Store merge: replace the addressed byte or halfword of the old word; half ignores a[0].
    function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d, logic [1:0] a, logic [1:0] sz);
        logic [4:0]  sh;
        logic [31:0] m;
        sh = sz[0] ? {a[1], 4'b0000} : {a, 3'b000};
        m  = (sz[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        return sz[1] ? d : (w & ~m) | ((d << sh) & m);
    endfunction

    assign req_ready = (state == IDLE) && !reset;

    // Single FSM with registered memory-port and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lane       <= '0;
            size       <= '0;
            sgn        <= 1'b0;
            write      <= 1'b0;
            wdata      <= '0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lane   <= req_addr[1:0];
                    size   <= req_size;
                    sgn    <= req_signed;
                    write  <= req_write;
                    wdata  <= req_wdata;
                    state  <= (req_write && req_size[1]) ? WR : RD;
                    mem_a  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_we <= req_write && req_size[1];
                    mem_wd <= (req_write && req_size[1]) ? req_wdata : '0;
                end
                RD: if (write) begin
                    state  <= WR;
                    mem_we <= 1'b1;
                    mem_wd <= merge(mem_rd, wdata, lane, size);
                end else begin
                    state      <= RESP;
                    mem_a      <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_fmt(mem_rd, lane, size, sgn);
                end
                WR: begin
                    state      <= RESP;
                    mem_we     <= 1'b0;
                    mem_a      <= '0;
                    mem_wd     <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and randomized checks of dmem_access_unit against a byte-level memory model
module tb_dmem_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_a = '0;
    logic [31:0] bd_d = '0;

    int          we_cnt = 0;
    int          resp_cnt = 0;
    int          bus_err = 0;
    logic [31:0] last_we_a = '0;
    logic [31:0] last_we_wd = '0;
    logic [31:0] last_ra = '0;

    dmem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[9:2]] <= mem_wd;
        else if (bd_we) mem[bd_a] <= bd_d;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                we_cnt++;
                last_we_a  = mem_a;
                last_we_wd = mem_wd;
            end
            if (resp_valid) resp_cnt++;
            if (mem_a[1:0] != 2'b00) bus_err++;
            if (req_ready && (mem_we || mem_a != 0 || mem_wd != 0)) bus_err++;
            if (!req_ready && !mem_we && !resp_valid) last_ra = mem_a;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic s);
        logic [7:0]  b [4];
        logic [31:0] r;
        int o, v;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (sz == 2'd0) begin
            v = int'(b[a % 4]);
            if (s && v > 127) v -= 256;
            r = v;
        end else if (sz == 2'd1) begin
            o = int'(a & 2);
            v = int'(b[o]) + 256 * int'(b[o + 1]);
            if (s && v > 32767) v -= 65536;
            r = v;
        end else begin
            o = int'(a % 4);
            for (int i = 0; i < 4; i++) r[8*i +: 8] = b[(i + o) % 4];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        logic [7:0]  b [4];
        logic [31:0] r;
        int o;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (sz == 2'd0) b[a % 4] = d[7:0];
        else if (sz == 2'd1) begin
            o = int'(a & 2);
            b[o] = d[7:0];
            b[o + 1] = d[15:8];
        end else return d;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_a = a; bd_d = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd);
        int we0, rs0, lat, idx, wait_n;
        logic [31:0] exp_rd;
        idx = int'(ad[9:2]);
        exp_rd = w ? 32'h0 : ref_load(ref_mem[idx], ad, sz, s);
        if (w) ref_mem[idx] = ref_store(ref_mem[idx], ad, sz, wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = s; req_addr = ad; req_wdata = wd;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        we0 = we_cnt; rs0 = resp_cnt;
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        rd = resp_rdata;
        #1;
        chk("rdata", rd, exp_rd);
        chk("latency", lat, (w && !sz[1]) ? 3 : 2);
        chk("we_cycles", we_cnt - we0, {31'b0, w});
        chk("resp_count", resp_cnt - rs0, 32'd1);
        if (w) begin
            chk("we_addr", last_we_a, ad & ~32'd3);
            chk("we_data", last_we_wd, ref_mem[idx]);
            chk("mem_word", mem[idx], ref_mem[idx]);
        end
        if (!w || !sz[1]) chk("rd_addr", last_ra, ad & ~32'd3);
    endtask

    initial begin
        logic [31:0] rd;
        int we0, rs0;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        req(1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344, rd);
        req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd);
        chk("tp_word_load", rd, 32'h1122_3344);
        req(1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_00AB, rd);
        chk("tp_byte_store", mem[64], 32'h11AB_3344);

        poke(8'd64, 32'h8001_7FFF);
        req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, rd);
        chk("tp_half_s", rd, 32'hFFFF_8001);
        req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd);
        chk("tp_half_u", rd, 32'h0000_8001);
        req(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, rd);
        chk("tp_byte_s", rd, 32'hFFFF_FFFF);

        poke(8'd64, 32'h1122_3344);
        req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, rd);
        chk("tp_rot8", rd, 32'h4411_2233);
        req(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, rd);
        chk("tp_rot24", rd, 32'h2233_4411);

        // reset during RD of a half store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_addr = 32'h100; req_wdata = 32'hBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        we0 = we_cnt; rs0 = resp_cnt;
        #2 reset = 1'b1;
        #1;
        chk("rd_rst_we", {31'b0, mem_we}, 32'd0);
        chk("rd_rst_ready", {31'b0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rd_rst_ready_after", {31'b0, req_ready}, 32'd1);
        chk("rd_rst_mem", mem[64], 32'h1122_3344);
        chk("rd_rst_no_we", we_cnt - we0, 32'd0);
        chk("rd_rst_no_resp", resp_cnt - rs0, 32'd0);

        // reset during WR of a word store
        poke(8'd65, 32'h5566_7788);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h104; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rs0 = resp_cnt;
        chk("wr_we_high", {31'b0, mem_we}, 32'd1);
        chk("wr_addr", mem_a, 32'h104);
        reset = 1'b1;
        #1;
        chk("wr_rst_we_async", {31'b0, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("wr_rst_mem", mem[65], 32'h5566_7788);
        chk("wr_rst_no_resp", resp_cnt - rs0, 32'd0);

        // second request held on req_valid during a byte store
        rs0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h102; req_wdata = 32'h0000_00AB;
        @(posedge clk);
        #1 req_write = 1'b0; req_size = 2'd2; req_addr = 32'h101; req_wdata = $urandom;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("held_not_ready", {31'b0, req_ready}, 32'd0);
            chk("held_resp", {31'b0, resp_valid}, {31'b0, k == 3});
        end
        @(negedge clk);
        chk("held_ready_again", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_load_valid", {31'b0, resp_valid}, 32'd1);
        chk("held_load_data", resp_rdata, 32'h4411_AB33);
        #1;
        chk("held_resp_count", resp_cnt - rs0, 32'd2);
        chk("held_mem", mem[64], 32'h11AB_3344);
        ref_mem[64] = 32'h11AB_3344;

        for (int n = 0; n < 150; n++)
            req(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 1023), $urandom, rd);

        chk("bus_rules", bus_err, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
